// File: rtl/player_pkg.sv
// ---------------------------------------------------------------------------
// player_pkg
// Shared types and constants for the player movement/animation controller.
//   dir_t      : facing direction; encoded so it equals the matching
//                standing sprite code
//   pstate_t   : controller life-cycle state
//   SPR_*      : sprite ROM indices read by the renderer
//   HACTIVE / VACTIVE / SPRITE_SIZE : display geometry used for arena limits
// ---------------------------------------------------------------------------
package player_pkg;

   typedef enum logic [1:0] {
      DOWN  = 2'd0,
      UP    = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      DYING,
      DEAD
   } pstate_t;

   localparam logic [2:0] SPR_DOWN   = 3'd0;
   localparam logic [2:0] SPR_UP     = 3'd1;
   localparam logic [2:0] SPR_LEFT   = 3'd2;
   localparam logic [2:0] SPR_RIGHT  = 3'd3;
   localparam logic [2:0] SPR_WALK_V = 3'd4;
   localparam logic [2:0] SPR_WALK_H = 3'd5;
   localparam logic [2:0] SPR_DEAD   = 3'd6;

   localparam int HACTIVE     = 800;
   localparam int VACTIVE     = 600;
   localparam int SPRITE_SIZE = 32;

   // Standing sprite for a facing direction.
   function automatic logic [2:0] face_sprite(input dir_t d);
      logic [2:0] s;
      case (d)
         UP:      s = SPR_UP;
         LEFT:    s = SPR_LEFT;
         RIGHT:   s = SPR_RIGHT;
         default: s = SPR_DOWN;
      endcase
      return s;
   endfunction

   // Walking frame: vertical for up/down, horizontal for left/right.
   function automatic logic [2:0] walk_sprite(input dir_t d);
      return (d == UP || d == DOWN) ? SPR_WALK_V : SPR_WALK_H;
   endfunction

endpackage

// File: rtl/player1_ctrl_tick_counter.sv
// ---------------------------------------------------------------------------
// tick_counter
// Modulo-N counter. Counts enabled cycles 0..N-1 and wraps back to 0.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset (count -> 0)
//   clear_i : synchronous clear, has priority over en_i
//   en_i    : advance the count this cycle
//   wrap_o  : high on the enabled cycle where the count is N-1 (wraps)
// ---------------------------------------------------------------------------
module tick_counter #(
   parameter int N = 8
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic en_i,
   output logic wrap_o
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign wrap_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/player1_ctrl.sv
// ---------------------------------------------------------------------------
// player1_ctrl
// Per-player movement and animation controller feeding the sprite renderer.
// Moves the sprite once per frame tick from the direction buttons (priority
// up > down > left > right), clamps to the arena, and runs the
// IDLE / WALK / DYING / DEAD life cycle. All outputs are registered.
//   clk         : pixel clock, rising edge
//   reset       : synchronous active-high reset
//   frame_tick  : one-cycle pulse at start of vertical blanking
//   btn_*       : direction buttons, level, 1 = pressed
//   killed      : one-cycle pulse, player hit (acts on any cycle)
//   respawn     : one-cycle pulse, restart from DEAD (acts on any cycle)
//   centerX1/Y1 : sprite top-left position, signed 11-bit
//   sprite_num  : sprite ROM index 0..6
//   alive       : 1 in IDLE/WALK
//   dying       : 1 in DYING
// ---------------------------------------------------------------------------
module player1_ctrl
   import player_pkg::*;
#(
   parameter int START_X     = 32,
   parameter int START_Y     = 32,
   parameter int X_MIN       = 32,
   parameter int X_MAX       = HACTIVE - 2 * SPRITE_SIZE,
   parameter int Y_MIN       = 32,
   parameter int Y_MAX       = VACTIVE - 2 * SPRITE_SIZE,
   parameter int SPEED       = 2,
   parameter int ANIM_DIV    = 8,
   parameter int DEATH_TICKS = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               killed,
   input  logic               respawn,
   output logic signed [10:0] centerX1,
   output logic signed [10:0] centerY1,
   output logic [2:0]         sprite_num,
   output logic               alive,
   output logic               dying
);

   localparam logic signed [10:0] START_X11 = 11'(START_X);
   localparam logic signed [10:0] START_Y11 = 11'(START_Y);
   localparam logic signed [11:0] X_MIN12   = 12'(X_MIN);
   localparam logic signed [11:0] X_MAX12   = 12'(X_MAX);
   localparam logic signed [11:0] Y_MIN12   = 12'(Y_MIN);
   localparam logic signed [11:0] Y_MAX12   = 12'(Y_MAX);
   localparam logic signed [11:0] SPEED12   = 12'(SPEED);

   pstate_t            state_q, state_d;
   dir_t               face_q, face_d;
   logic               phase_q, phase_d;
   logic signed [10:0] x_q, x_d;
   logic signed [10:0] y_q, y_d;
   logic [2:0]         spr_q, spr_d;
   logic               alive_q, alive_d;
   logic               dying_q, dying_d;

   logic               any_btn;
   dir_t               btn_dir;
   logic signed [11:0] nx, ny;

   logic               anim_clr, anim_en, anim_wrap;
   logic               death_clr, death_en, death_wrap;

   assign any_btn = btn_up | btn_down | btn_left | btn_right;

   always_comb begin
      btn_dir = DOWN;
      if (btn_up) begin
         btn_dir = UP;
      end else if (btn_down) begin
         btn_dir = DOWN;
      end else if (btn_left) begin
         btn_dir = LEFT;
      end else if (btn_right) begin
         btn_dir = RIGHT;
      end
   end

   // Candidate position at 12-bit signed, one axis stepped, then clamped so
   // the truncation back to 11 bits is always lossless.
   always_comb begin
      nx = {x_q[10], x_q};
      ny = {y_q[10], y_q};
      case (btn_dir)
         UP:      ny = ny - SPEED12;
         DOWN:    ny = ny + SPEED12;
         LEFT:    nx = nx - SPEED12;
         default: nx = nx + SPEED12;
      endcase
      if (nx < X_MIN12) begin
         nx = X_MIN12;
      end else if (nx > X_MAX12) begin
         nx = X_MAX12;
      end
      if (ny < Y_MIN12) begin
         ny = Y_MIN12;
      end else if (ny > Y_MAX12) begin
         ny = Y_MAX12;
      end
   end

   // Counters are held at zero outside their owning state, so entry into
   // WALK or DYING always starts from 0 without an explicit entry pulse.
   always_comb begin
      anim_clr  = (state_q != WALK);
      anim_en   = (state_q == WALK) && frame_tick && any_btn && !killed;
      death_clr = (state_q != DYING);
      death_en  = (state_q == DYING) && frame_tick;
   end

   tick_counter #(.N(ANIM_DIV)) u_anim_cnt (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (anim_clr),
      .en_i    (anim_en),
      .wrap_o  (anim_wrap)
   );

   tick_counter #(.N(DEATH_TICKS)) u_death_cnt (
      .clk_i   (clk),
      .reset_i (reset),
      .clear_i (death_clr),
      .en_i    (death_en),
      .wrap_o  (death_wrap)
   );

   always_comb begin
      state_d = state_q;
      face_d  = face_q;
      phase_d = phase_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         IDLE, WALK: begin
            if (killed) begin
               state_d = DYING;
            end else if (frame_tick) begin
               if (any_btn) begin
                  face_d = btn_dir;
                  x_d    = nx[10:0];
                  y_d    = ny[10:0];
                  if (state_q == IDLE) begin
                     state_d = WALK;
                     phase_d = 1'b0;
                  end else if (anim_wrap) begin
                     phase_d = ~phase_q;
                  end
               end else begin
                  state_d = IDLE;
                  phase_d = 1'b0;
               end
            end
         end
         DYING: begin
            if (death_wrap) begin
               state_d = DEAD;
            end
         end
         default: begin
            if (respawn) begin
               state_d = IDLE;
               face_d  = DOWN;
               phase_d = 1'b0;
               x_d     = START_X11;
               y_d     = START_Y11;
            end
         end
      endcase
   end

   // Outputs decoded from next state so they are registered alongside it.
   always_comb begin
      case (state_d)
         DYING, DEAD: spr_d = SPR_DEAD;
         WALK:        spr_d = phase_d ? walk_sprite(face_d) : face_sprite(face_d);
         default:     spr_d = face_sprite(face_d);
      endcase
      alive_d = (state_d == IDLE) || (state_d == WALK);
      dying_d = (state_d == DYING);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         face_q  <= DOWN;
         phase_q <= 1'b0;
         x_q     <= START_X11;
         y_q     <= START_Y11;
         spr_q   <= SPR_DOWN;
         alive_q <= 1'b1;
         dying_q <= 1'b0;
      end else begin
         state_q <= state_d;
         face_q  <= face_d;
         phase_q <= phase_d;
         x_q     <= x_d;
         y_q     <= y_d;
         spr_q   <= spr_d;
         alive_q <= alive_d;
         dying_q <= dying_d;
      end
   end

   assign centerX1   = x_q;
   assign centerY1   = y_q;
   assign sprite_num = spr_q;
   assign alive      = alive_q;
   assign dying      = dying_q;

endmodule
